// File: rtl/game_pkg.sv
// Shared state encoding for the game master FSM and the VGA display wrapper.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WIN  = 2'b10,
    ST_LOSE = 2'b11
  } state_t;

  localparam int NUM_BTN = 4;

endpackage

// File: rtl/button_debouncer.sv
// Per-button debouncer: 2-FF synchroniser, stable-count filter and a one-cycle rising-edge pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic IN,
  output logic LEVEL,
  output logic RISE_PULSE
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      LEVEL      <= 1'b0;
      level_d    <= 1'b0;
      RISE_PULSE <= 1'b0;
      cnt        <= '0;
    end else begin
      sync1      <= IN;
      sync2      <= sync1;
      level_d    <= LEVEL;
      // Pulse lags the flip by one cycle so it is a clean registered output.
      RISE_PULSE <= LEVEL & ~level_d;
      if (sync2 == LEVEL) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        LEVEL <= ~LEVEL;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/game_master_fsm.sv
// Game master FSM: debounces buttons, tracks score, decides win/lose and times the end screens.
module game_master_fsm
  import game_pkg::*;
#(
  parameter int WIN_SCORE        = 10,
  parameter int SCORE_WIDTH      = 4,
  parameter int DEBOUNCE_CYCLES  = 1_000_000,
  parameter int WIN_HOLD_CYCLES  = 500_000_000,
  parameter int LOSE_HOLD_CYCLES = 300_000_000,
  parameter int TIMER_WIDTH      = 29
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [3:0]             BTN,
  input  logic                   TARGET_REACHED,
  input  logic                   COLLISION,
  output logic [1:0]             MSM_STATE,
  output logic [SCORE_WIDTH-1:0] SCORE,
  output logic                   GAME_RESET,
  output logic [3:0]             BTN_PULSE
);

  // state | meaning
  // IDLE  | font screen, waiting for any button press
  // PLAY  | game running, counting targets, watching for collision
  // WIN   | animated screen until hold timer expires or a press
  // LOSE  | solid screen until hold timer expires or a press

  localparam logic [SCORE_WIDTH-1:0] SCORE_WIN = SCORE_WIDTH'(WIN_SCORE);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;
  localparam logic [TIMER_WIDTH-1:0] WIN_LAST  = TIMER_WIDTH'(WIN_HOLD_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] LOSE_LAST = TIMER_WIDTH'(LOSE_HOLD_CYCLES - 1);

  state_t                   state;
  state_t                   state_next;
  logic [SCORE_WIDTH-1:0]   score_next;
  logic [SCORE_WIDTH-1:0]   score_inc;
  logic [TIMER_WIDTH-1:0]   timer;
  logic [TIMER_WIDTH-1:0]   timer_next;
  logic [TIMER_WIDTH-1:0]   hold_last;
  logic                     game_reset_next;
  logic                     any_press;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .CLK       (CLK),
      .RESET     (RESET),
      .IN        (BTN[i]),
      .LEVEL     (),
      .RISE_PULSE(BTN_PULSE[i])
    );
  end

  assign any_press = |BTN_PULSE;
  assign score_inc = SCORE + SCORE_WIDTH'(1);
  assign hold_last = (state == ST_WIN) ? WIN_LAST : LOSE_LAST;
  assign MSM_STATE = state;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      SCORE      <= '0;
      GAME_RESET <= 1'b0;
      timer      <= '0;
    end else begin
      state      <= state_next;
      SCORE      <= score_next;
      GAME_RESET <= game_reset_next;
      timer      <= timer_next;
    end
  end

  always_comb begin
    state_next      = state;
    score_next      = SCORE;
    timer_next      = '0;
    game_reset_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_press) begin
          state_next      = ST_PLAY;
          score_next      = '0;
          game_reset_next = 1'b1;
        end
      end
      ST_PLAY: begin
        // Collision wins over a same-cycle target so a fatal move never scores.
        if (COLLISION) begin
          state_next = ST_LOSE;
        end else if (TARGET_REACHED && (SCORE != SCORE_MAX)) begin
          score_next = score_inc;
          if (score_inc == SCORE_WIN) begin
            state_next = ST_WIN;
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (any_press || (timer == hold_last)) begin
          state_next = ST_IDLE;
        end else begin
          timer_next = timer + TIMER_WIDTH'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_game_master_fsm.sv
// Scoreboard-driven bench for game_master_fsm with short debounce and hold times.
module tb_game_master_fsm;

  localparam int DC        = 4;
  localparam int WIN_SCORE = 3;
  localparam int WIN_HOLD  = 20;
  localparam int LOSE_HOLD = 10;

  logic       CLK;
  logic       RESET;
  logic [3:0] BTN;
  logic       TARGET_REACHED;
  logic       COLLISION;
  logic [1:0] MSM_STATE;
  logic [3:0] SCORE;
  logic       GAME_RESET;
  logic [3:0] BTN_PULSE;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_total = 0;
  int gr_total    = 0;
  logic [5:0] exp_q[$];

  game_master_fsm #(
    .WIN_SCORE       (WIN_SCORE),
    .SCORE_WIDTH     (4),
    .DEBOUNCE_CYCLES (DC),
    .WIN_HOLD_CYCLES (WIN_HOLD),
    .LOSE_HOLD_CYCLES(LOSE_HOLD),
    .TIMER_WIDTH     (29)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .BTN           (BTN),
    .TARGET_REACHED(TARGET_REACHED),
    .COLLISION     (COLLISION),
    .MSM_STATE     (MSM_STATE),
    .SCORE         (SCORE),
    .GAME_RESET    (GAME_RESET),
    .BTN_PULSE     (BTN_PULSE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(negedge CLK) begin
    if (BTN_PULSE != 4'b0000) pulse_total++;
    if (GAME_RESET) gr_total++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic press_button(input int b, output int lat, output logic [3:0] pv);
    lat = -1;
    pv  = 4'b0000;
    BTN[b] = 1'b1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      tick();
      if (BTN_PULSE != 4'b0000) begin
        lat = k;
        pv  = BTN_PULSE;
      end
    end
  endtask

  task automatic release_button(input int b);
    BTN[b] = 1'b0;
    repeat (12) tick();
  endtask

  task automatic score_event(input logic coll, input logic [1:0] st, input logic [3:0] sc);
    logic [5:0] e;
    TARGET_REACHED = 1'b1;
    COLLISION      = coll;
    exp_q.push_back({st, sc});
    tick();
    TARGET_REACHED = 1'b0;
    COLLISION      = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if ({MSM_STATE, SCORE} !== e) begin
      n_fail++;
      $display("FAIL score_event: state/score got %b/%0d expected %b/%0d",
               MSM_STATE, SCORE, e[5:4], e[3:0]);
    end
  endtask

  task automatic test_reset();
    int p0, g0;
    RESET = 1'b1;
    #12;
    RESET = 1'b0;
    p0 = pulse_total;
    g0 = gr_total;
    repeat (50) tick();
    n_checks++;
    if (MSM_STATE !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b expected 00", MSM_STATE); end
    n_checks++;
    if (SCORE !== 4'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", SCORE); end
    n_checks++;
    if (GAME_RESET !== 1'b0 || gr_total != g0) begin
      n_fail++; $display("FAIL reset_game_reset: got %b (count %0d) expected 0", GAME_RESET, gr_total - g0);
    end
    n_checks++;
    if (BTN_PULSE !== 4'b0000 || pulse_total != p0) begin
      n_fail++; $display("FAIL reset_btn_pulse: got %b (count %0d) expected 0000", BTN_PULSE, pulse_total - p0);
    end
  endtask

  task automatic test_press_start();
    int p0, g0, lat;
    logic [3:0] pv;
    p0 = pulse_total;
    BTN[3] = 1'b1;
    repeat (2) tick();
    BTN[3] = 1'b0;
    repeat (12) tick();
    n_checks++;
    if (pulse_total != p0 || MSM_STATE !== 2'b00) begin
      n_fail++; $display("FAIL glitch: pulses %0d state %b expected 0 pulses state 00", pulse_total - p0, MSM_STATE);
    end
    p0 = pulse_total;
    g0 = gr_total;
    press_button(3, lat, pv);
    n_checks++;
    if (lat != DC + 3 || pv !== 4'b1000) begin
      n_fail++; $display("FAIL press_latency: latency %0d pulse %b expected %0d 1000", lat, pv, DC + 3);
    end
    tick();
    n_checks++;
    if (MSM_STATE !== 2'b01 || GAME_RESET !== 1'b1 || BTN_PULSE !== 4'b0000) begin
      n_fail++; $display("FAIL start_play: state %b game_reset %b pulse %b expected 01 1 0000", MSM_STATE, GAME_RESET, BTN_PULSE);
    end
    tick();
    n_checks++;
    if (MSM_STATE !== 2'b01 || GAME_RESET !== 1'b0) begin
      n_fail++; $display("FAIL game_reset_width: state %b game_reset %b expected 01 0", MSM_STATE, GAME_RESET);
    end
    tick();
    release_button(3);
    n_checks++;
    if (pulse_total != p0 + 1 || gr_total != g0 + 1) begin
      n_fail++; $display("FAIL press_once: pulses %0d resets %0d expected 1 1", pulse_total - p0, gr_total - g0);
    end
  endtask

  task automatic test_win_timeout();
    int n;
    for (int i = 1; i <= WIN_SCORE; i++) begin
      repeat (2) tick();
      score_event(1'b0, (i == WIN_SCORE) ? 2'b10 : 2'b01, 4'(i));
    end
    n = -1;
    for (int k = 1; k <= 40 && n < 0; k++) begin
      tick();
      if (MSM_STATE == 2'b00) n = k;
    end
    n_checks++;
    if (n != WIN_HOLD || SCORE !== 4'd3) begin
      n_fail++; $display("FAIL win_hold: cycles %0d score %0d expected %0d 3", n, SCORE, WIN_HOLD);
    end
  endtask

  task automatic test_lose_priority();
    int lat, n;
    logic [3:0] pv;
    press_button(2, lat, pv);
    tick();
    n_checks++;
    if (MSM_STATE !== 2'b01 || SCORE !== 4'd0) begin
      n_fail++; $display("FAIL restart_clear: state %b score %0d expected 01 0", MSM_STATE, SCORE);
    end
    release_button(2);
    score_event(1'b0, 2'b01, 4'd1);
    tick();
    score_event(1'b1, 2'b11, 4'd1);
    n = -1;
    for (int k = 1; k <= 40 && n < 0; k++) begin
      tick();
      if (MSM_STATE == 2'b00) n = k;
    end
    n_checks++;
    if (n != LOSE_HOLD || SCORE !== 4'd1) begin
      n_fail++; $display("FAIL lose_hold: cycles %0d score %0d expected %0d 1", n, SCORE, LOSE_HOLD);
    end
  endtask

  task automatic test_win_early_exit();
    int lat;
    logic [3:0] pv;
    press_button(2, lat, pv);
    tick();
    release_button(2);
    for (int i = 1; i <= WIN_SCORE; i++) begin
      score_event(1'b0, (i == WIN_SCORE) ? 2'b10 : 2'b01, 4'(i));
    end
    repeat (4) tick();
    press_button(0, lat, pv);
    n_checks++;
    if (lat != DC + 3 || pv !== 4'b0001 || MSM_STATE !== 2'b10) begin
      n_fail++; $display("FAIL win_press: latency %0d pulse %b state %b expected %0d 0001 10", lat, pv, MSM_STATE, DC + 3);
    end
    tick();
    n_checks++;
    if (MSM_STATE !== 2'b00 || SCORE !== 4'd3) begin
      n_fail++; $display("FAIL win_early_idle: state %b score %0d expected 00 3", MSM_STATE, SCORE);
    end
    release_button(0);
    press_button(0, lat, pv);
    tick();
    n_checks++;
    if (MSM_STATE !== 2'b01 || SCORE !== 4'd0 || GAME_RESET !== 1'b1) begin
      n_fail++; $display("FAIL second_press: state %b score %0d game_reset %b expected 01 0 1", MSM_STATE, SCORE, GAME_RESET);
    end
    release_button(0);
  endtask

  task automatic test_reset_mid_play();
    int lat, p0, g0;
    logic [3:0] pv;
    score_event(1'b0, 2'b01, 4'd1);
    score_event(1'b0, 2'b01, 4'd2);
    press_button(1, lat, pv);
    tick();
    n_checks++;
    if (lat != DC + 3 || pv !== 4'b0010 || MSM_STATE !== 2'b01 || SCORE !== 4'd2) begin
      n_fail++; $display("FAIL play_button: latency %0d pulse %b state %b score %0d expected %0d 0010 01 2",
                         lat, pv, MSM_STATE, SCORE, DC + 3);
    end
    #2;
    RESET = 1'b1;
    BTN   = 4'b0000;
    #1;
    n_checks++;
    if (MSM_STATE !== 2'b00 || SCORE !== 4'd0 || BTN_PULSE !== 4'b0000 || GAME_RESET !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: state %b score %0d pulse %b game_reset %b expected 00 0 0000 0",
                         MSM_STATE, SCORE, BTN_PULSE, GAME_RESET);
    end
    repeat (2) tick();
    RESET = 1'b0;
    p0 = pulse_total;
    g0 = gr_total;
    repeat (20) tick();
    n_checks++;
    if (pulse_total != p0 || gr_total != g0 || MSM_STATE !== 2'b00) begin
      n_fail++; $display("FAIL post_reset_quiet: pulses %0d resets %0d state %b expected 0 0 00",
                         pulse_total - p0, gr_total - g0, MSM_STATE);
    end
  endtask

  initial begin
    RESET          = 1'b1;
    BTN            = 4'b0000;
    TARGET_REACHED = 1'b0;
    COLLISION      = 1'b0;
    test_reset();
    test_press_start();
    test_win_timeout();
    test_lose_priority();
    test_win_early_exit();
    test_reset_mid_play();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
